// File: rtl/pipe_front_regs.sv
// Front-end pipeline state for the 16-bit, 8-register in-order core:
// PC, IF/ID latch, ID/EX control latch and a saturating stall counter.
// Hazard-facing outputs come only from flops or from decode of the
// IF/ID flops, so no input reaches them combinationally.
module pipe_front_regs #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [15:0]      imem_rdata,
    input  logic             pc_write,
    input  logic             if_id_write,
    input  logic             id_ex_flush,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    output logic [PC_W-1:0]  pc,
    output logic             if_id_valid,
    output logic [PC_W-1:0]  if_id_pc,
    output logic [15:0]      if_id_instr,
    output logic [2:0]       if_id_rs1,
    output logic [2:0]       if_id_rs2,
    output logic             id_ex_valid,
    output logic             id_ex_memread,
    output logic             id_ex_memwrite,
    output logic             id_ex_regwrite,
    output logic [2:0]       id_ex_rd,
    output logic [2:0]       id_ex_rs1,
    output logic [2:0]       id_ex_rs2,
    output logic [15:0]      id_ex_imm,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic        valid;
        logic        memread;
        logic        memwrite;
        logic        regwrite;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] imm;
    } id_ex_t;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             if_id_valid_q, if_id_valid_d;
    logic [PC_W-1:0]  if_id_pc_q, if_id_pc_d;
    logic [15:0]      if_id_instr_q, if_id_instr_d;
    id_ex_t           id_ex_q, id_ex_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    id_ex_t           dec;

    logic [3:0]  op;
    logic [2:0]  fa, fb, fc;
    logic [15:0] simm;

    assign op   = if_id_instr_q[15:12];
    assign fa   = if_id_instr_q[11:9];
    assign fb   = if_id_instr_q[8:6];
    assign fc   = if_id_instr_q[5:3];
    assign simm = {{10{if_id_instr_q[5]}}, if_id_instr_q[5:0]};

    // Decode the IF/ID latch; an invalid entry decodes to a bubble.
    always_comb begin
        dec = '0;
        if (if_id_valid_q) begin
            dec.valid = 1'b1;
            case (op)
                4'd1, 4'd2: begin
                    dec.rd = fa; dec.rs1 = fb; dec.rs2 = fc; dec.regwrite = 1'b1;
                end
                4'd3: begin
                    dec.rd = fa; dec.rs1 = fb; dec.memread = 1'b1;
                    dec.regwrite = 1'b1; dec.imm = simm;
                end
                4'd4: begin
                    dec.rs2 = fa; dec.rs1 = fb; dec.memwrite = 1'b1; dec.imm = simm;
                end
                4'd5: begin
                    dec.rs1 = fa; dec.rs2 = fb; dec.imm = simm;
                end
                default: ;
            endcase
        end
    end

    // Next state: redirect beats stall; flush bubbles ID/EX whenever not redirecting.
    always_comb begin
        pc_d          = pc_q;
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        id_ex_d       = '0;
        stall_count_d = stall_count_q;
        if (branch_taken) begin
            pc_d          = branch_target;
            if_id_valid_d = 1'b0;
            if_id_pc_d    = '0;
            if_id_instr_d = '0;
        end else begin
            if (pc_write) pc_d = pc_q + PC_W'(1);
            if (if_id_write) begin
                if_id_valid_d = 1'b1;
                if_id_pc_d    = pc_q;
                if_id_instr_d = imem_rdata;
            end
            if (!id_ex_flush) id_ex_d = dec;
            if (!pc_write && stall_count_q != '1)
                stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= '0;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= '0;
            id_ex_q       <= '0;
            stall_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            id_ex_q       <= id_ex_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign pc             = pc_q;
    assign imem_addr      = pc_q;
    assign if_id_valid    = if_id_valid_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_rs1      = dec.rs1;
    assign if_id_rs2      = dec.rs2;
    assign id_ex_valid    = id_ex_q.valid;
    assign id_ex_memread  = id_ex_q.memread;
    assign id_ex_memwrite = id_ex_q.memwrite;
    assign id_ex_regwrite = id_ex_q.regwrite;
    assign id_ex_rd       = id_ex_q.rd;
    assign id_ex_rs1      = id_ex_q.rs1;
    assign id_ex_rs2      = id_ex_q.rs2;
    assign id_ex_imm      = id_ex_q.imm;
    assign stall_count    = stall_count_q;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Bench for pipe_front_regs: directed steps plus random traffic against
// a transaction-level model of the front end.
module tb_pipe_front_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        pc_write = 1'b1, if_id_write = 1'b1, id_ex_flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic [7:0]  pc, if_id_pc;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [2:0]  if_id_rs1, if_id_rs2;
    logic        id_ex_valid, id_ex_memread, id_ex_memwrite, id_ex_regwrite;
    logic [2:0]  id_ex_rd, id_ex_rs1, id_ex_rs2;
    logic [15:0] id_ex_imm;
    logic [15:0] stall_count;

    logic [15:0] mem [256];
    assign imem_rdata = mem[imem_addr];

    always #5 clk = ~clk;

    pipe_front_regs #(.PC_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_flush(id_ex_flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(pc), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .id_ex_valid(id_ex_valid), .id_ex_memread(id_ex_memread),
        .id_ex_memwrite(id_ex_memwrite), .id_ex_regwrite(id_ex_regwrite),
        .id_ex_rd(id_ex_rd), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
        .id_ex_imm(id_ex_imm), .stall_count(stall_count)
    );

    // Reference: decoded instruction as a record of fields
    typedef struct packed {
        logic        v, mr, mw, rw;
        logic [2:0]  rd, rs1, rs2;
        logic [15:0] imm;
    } dec_t;

    int total = 0;
    int bad   = 0;

    logic [7:0]  m_pc;
    logic        m_fv;
    logic [7:0]  m_fpc;
    logic [15:0] m_fi;
    dec_t        m_ex;
    int          m_cnt;

    function automatic dec_t decode(input logic v, input logic [15:0] i);
        dec_t d;
        int   op, a, b, c, imm;
        d = '0;
        op  = i[15:12]; a = i[11:9]; b = i[8:6]; c = i[5:3];
        imm = i[5] ? int'(i[5:0]) - 64 : int'(i[5:0]);
        if (!v) return d;
        d.v = 1'b1;
        if (op == 1 || op == 2) begin d.rd = a[2:0]; d.rs1 = b[2:0]; d.rs2 = c[2:0]; d.rw = 1'b1; end
        if (op == 3) begin d.rd = a[2:0]; d.rs1 = b[2:0]; d.mr = 1'b1; d.rw = 1'b1; end
        if (op == 4) begin d.rs2 = a[2:0]; d.rs1 = b[2:0]; d.mw = 1'b1; end
        if (op == 5) begin d.rs1 = a[2:0]; d.rs2 = b[2:0]; end
        if (op >= 3 && op <= 5) d.imm = 16'(imm);
        return d;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_fv = 0; m_fpc = 0; m_fi = 0; m_ex = '0; m_cnt = 0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        dec_t  fd, od;
        fd = decode(m_fv, m_fi);
        od = {id_ex_valid, id_ex_memread, id_ex_memwrite, id_ex_regwrite,
              id_ex_rd, id_ex_rs1, id_ex_rs2, id_ex_imm};
        check({where, ".pc"},    64'(pc), 64'(m_pc));
        check({where, ".addr"},  64'(imem_addr), 64'(m_pc));
        check({where, ".ifid"},  64'({if_id_valid, if_id_pc, if_id_instr}), 64'({m_fv, m_fpc, m_fi}));
        check({where, ".ifrs"},  64'({if_id_rs1, if_id_rs2}), 64'({fd.rs1, fd.rs2}));
        check({where, ".idex"},  64'(od), 64'(m_ex));
        check({where, ".cnt"},   64'(stall_count), 64'(m_cnt));
    endtask

    // Apply one cycle of inputs, advance the model, sample 1 ns after the edge.
    task automatic step(input logic br, input logic [7:0] tgt, input logic pw,
                        input logic iw, input logic fl, input logic chk);
        logic [7:0]  n_pc, n_fpc;
        logic        n_fv;
        logic [15:0] n_fi;
        dec_t        n_ex;
        branch_taken = br; branch_target = tgt;
        pc_write = pw; if_id_write = iw; id_ex_flush = fl;
        if (br) begin
            n_pc = tgt; n_fv = 0; n_fpc = 0; n_fi = 0; n_ex = '0;
        end else begin
            n_pc = pw ? 8'((int'(m_pc) + 1) % 256) : m_pc;
            n_fv = iw ? 1'b1 : m_fv;
            n_fpc = iw ? m_pc : m_fpc;
            n_fi = iw ? mem[m_pc] : m_fi;
            n_ex = fl ? '0 : decode(m_fv, m_fi);
            if (!pw && m_cnt < 65535) m_cnt++;
        end
        @(posedge clk);
        m_pc = n_pc; m_fv = n_fv; m_fpc = n_fpc; m_fi = n_fi; m_ex = n_ex;
        #1;
        if (chk) check_all("step");
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1298;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Free run with ADD r1,r2,r3 everywhere
        run(4);
        check("run.pc", 64'(pc), 64'd4);
        check("run.add", 64'({id_ex_rd, id_ex_rs1, id_ex_rs2, id_ex_regwrite}),
              64'({3'd1, 3'd2, 3'd3, 1'b1}));

        // Load-use: LW r1 then ADD r2,r1,r3
        mem[8'h10] = 16'h3280;
        mem[8'h11] = 16'h1458;
        step(1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 1'b1);
        run(2);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("lu.pc", 64'(pc), 64'h12);
        check("lu.instr", 64'(if_id_instr), 64'h1458);
        check("lu.bubble", 64'({id_ex_valid, id_ex_memread}), 64'd0);
        check("lu.cnt", 64'(stall_count), 64'd1);
        run(1);
        check("lu.add", 64'({id_ex_valid, id_ex_rd, id_ex_rs1, id_ex_rs2}),
              64'({1'b1, 3'd2, 3'd1, 3'd3}));

        // Branch together with a stall; SW at the target
        mem[8'h40] = 16'h4ABE;
        step(1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b1);
        check("br.pc", 64'(pc), 64'h40);
        check("br.vld", 64'({if_id_valid, id_ex_valid}), 64'd0);
        check("br.cnt", 64'(stall_count), 64'd1);
        run(2);
        check("sw.fields", 64'({id_ex_rs2, id_ex_rs1, id_ex_rd, id_ex_memwrite}),
              64'({3'd5, 3'd2, 3'd0, 1'b1}));
        check("sw.imm", 64'(id_ex_imm), 64'hFFFE);

        // PC wrap
        step(1'b1, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b1);
        run(1);
        check("wrap.ff", 64'(pc), 64'hFF);
        run(1);
        check("wrap.00", 64'(pc), 64'h00);

        // Random traffic over random memory
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(0, 1) == 0) mem[i][15:12] = 4'($urandom_range(0, 5));
        end
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 7) == 0, 8'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0, 1'b1);
        end

        // Stall counter saturation
        for (int k = 0; k < 65539; k++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check_all("sat");
        check("sat.cnt", 64'(stall_count), 64'hFFFF);

        // Asynchronous reset mid-cycle during a stall
        pc_write = 1'b0; if_id_write = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("arst");
        @(posedge clk);
        #1;
        check_all("arst.hold");
        rst_n = 1'b1;
        run(1);
        check("arst.fetch", 64'({pc, if_id_valid, if_id_pc}), 64'({8'h01, 1'b1, 8'h00}));
        run(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
